mul_lanes_pipe: RTL and testbench

//  Multi-lane pipelined successor of the single-lane MUL stage. Each cycle it multiplies NUM_LANES

---
 rtl/mul_lanes_pipe.sv | 151 +++++++++++++++
 tb/tb_mul_lanes_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_lanes_pipe.sv
// Multi-lane pipelined multiplier stage: input FIFO, iteration-tracked issue, PIPE_STAGES-deep
// product pipeline with global stall, side-info passthrough, done pulse and sticky overflow.
module mul_lanes_pipe #(
    parameter int unsigned NUM_LANES              = 4,
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned SIGNED_MODE            = 0,
    parameter int unsigned PIPE_STAGES            = 2,
    parameter int unsigned FIFO_DEPTH             = 4,
    parameter int unsigned LOG_MAX_ITERS          = 16,
    parameter int unsigned LOG_MAX_READS_PER_ITER = 16,
    localparam int unsigned SIDE_W = NUM_LANES * NUM_LANES + NUM_LANES,
    localparam int unsigned IO_W   = NUM_LANES * 2 * DATA_WIDTH + SIDE_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [IO_W-1:0]                   data_in,
    input  logic                              valid_in,
    output logic                              avail_out,
    output logic [IO_W-1:0]                   data_out,
    output logic                              valid_out,
    input  logic                              avail_in,
    output logic                              done,
    output logic                              overflow
);
    localparam int unsigned PW      = 2 * DATA_WIDTH;
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned ZeroLsb = IO_W - SIDE_W;
    localparam int unsigned ItW     = LOG_MAX_ITERS;
    localparam int unsigned RdW     = LOG_MAX_READS_PER_ITER;
    localparam logic [PtrW:0] CntFull  = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0] CntAvail = (PtrW + 1)'(FIFO_DEPTH - 2);

    logic [IO_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            ovf_q;
    logic            full, empty, push, pop;

    logic            en_q;
    logic [ItW-1:0]  iters_q;
    logic [RdW-1:0]  reads_q, reads_saved_q;
    logic            issue, last_issue;

    logic [IO_W-1:0]        head;
    logic [IO_W-1:0]        prod_word;
    logic [DATA_WIDTH-1:0]  act, wgt;
    logic [PW-1:0]          act_x, wgt_x, prod;

    logic [IO_W-1:0]        pipe_data_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] pipe_vld_q, pipe_tag_q;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CntFull);
    assign issue      = en_q & ~empty & avail_in;
    assign pop        = issue;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push       = valid_in & (~full | pop);
    assign last_issue = issue & ~configure & (reads_q == RdW'(1)) & (iters_q == ItW'(1));
    assign avail_out  = (count_q <= CntAvail);
    assign overflow   = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
            if (valid_in && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q          <= 1'b0;
            iters_q       <= '0;
            reads_q       <= '0;
            reads_saved_q <= '0;
        end else if (configure) begin
            iters_q       <= num_iters;
            reads_q       <= num_reads_per_iter;
            reads_saved_q <= num_reads_per_iter;
            en_q          <= (num_iters != '0) && (num_reads_per_iter != '0);
        end else if (issue) begin
            if (last_issue) begin
                en_q <= 1'b0;
            end else if (reads_q == RdW'(1)) begin
                iters_q <= iters_q - ItW'(1);
                reads_q <= reads_saved_q;
            end else begin
                reads_q <= reads_q - RdW'(1);
            end
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Operands are extended to product width so one modular multiply serves both modes.
    always_comb begin
        prod_word = '0;
        act       = '0;
        wgt       = '0;
        act_x     = '0;
        wgt_x     = '0;
        prod      = '0;
        prod_word[IO_W-1 -: SIDE_W] = head[IO_W-1 -: SIDE_W];
        for (int i = 0; i < NUM_LANES; i++) begin
            act   = head[i*PW +: DATA_WIDTH];
            wgt   = head[i*PW+DATA_WIDTH +: DATA_WIDTH];
            act_x = (SIGNED_MODE != 0) ? {{DATA_WIDTH{act[DATA_WIDTH-1]}}, act}
                                       : {{DATA_WIDTH{1'b0}}, act};
            wgt_x = (SIGNED_MODE != 0) ? {{DATA_WIDTH{wgt[DATA_WIDTH-1]}}, wgt}
                                       : {{DATA_WIDTH{1'b0}}, wgt};
            prod  = act_x * wgt_x;
            if (!head[ZeroLsb + i]) prod_word[i*PW +: PW] = prod;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) pipe_data_q[s] <= '0;
        end else if (avail_in) begin
            pipe_vld_q[0]  <= issue;
            pipe_tag_q[0]  <= last_issue;
            pipe_data_q[0] <= prod_word;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                pipe_vld_q[s]  <= pipe_vld_q[s-1];
                pipe_tag_q[s]  <= pipe_tag_q[s-1];
                pipe_data_q[s] <= pipe_data_q[s-1];
            end
        end
    end

    assign valid_out = pipe_vld_q[PIPE_STAGES-1] & avail_in;
    assign data_out  = pipe_data_q[PIPE_STAGES-1];
    assign done      = valid_out & pipe_tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_mul_lanes_pipe.sv
// Bench for mul_lanes_pipe: arithmetic lane model with scoreboard queues, plus directed
// vectors with literal expectations (unsigned and signed instances).
module tb_mul_lanes_pipe;
    localparam int NL     = 4;
    localparam int DW     = 8;
    localparam int SIDE_W = NL * NL + NL;
    localparam int IO_W   = NL * 2 * DW + SIDE_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            configure, s_configure;
    logic [15:0]     num_iters, num_reads;
    logic [IO_W-1:0] data_in, s_data_in;
    logic            valid_in, s_valid_in;
    logic            avail_in;
    logic            avail_out, s_avail_out;
    logic [IO_W-1:0] data_out, s_data_out;
    logic            valid_out, s_valid_out;
    logic            done, s_done;
    logic            overflow, s_overflow;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0, s_out_cnt = 0;
    int job_start = 0, job_total = 0;
    logic [IO_W-1:0] last_out, s_last_out;
    logic            s_last_done;
    logic [IO_W-1:0] q[$];
    logic [IO_W-1:0] sq[$];

    always #5 clk = ~clk;

    mul_lanes_pipe #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .SIGNED_MODE(0), .PIPE_STAGES(2), .FIFO_DEPTH(4),
        .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
    ) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
        .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
        .avail_in(avail_in), .done(done), .overflow(overflow)
    );

    mul_lanes_pipe #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .SIGNED_MODE(1), .PIPE_STAGES(2), .FIFO_DEPTH(4),
        .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
    ) dut_s (
        .clk(clk), .rst(rst), .configure(s_configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .data_in(s_data_in), .valid_in(s_valid_in),
        .avail_out(s_avail_out), .data_out(s_data_out), .valid_out(s_valid_out),
        .avail_in(avail_in), .done(s_done), .overflow(s_overflow)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [IO_W-1:0] mk(input int a0, input int b0, input int a1, input int b1,
                                           input int a2, input int b2, input int a3, input int b3,
                                           input logic [SIDE_W-1:0] side);
        logic [IO_W-1:0] w;
        w = '0;
        w[7:0]   = a0[7:0];  w[15:8]  = b0[7:0];
        w[23:16] = a1[7:0];  w[31:24] = b1[7:0];
        w[39:32] = a2[7:0];  w[47:40] = b2[7:0];
        w[55:48] = a3[7:0];  w[63:56] = b3[7:0];
        w[IO_W-1 -: SIDE_W] = side;
        return w;
    endfunction

    // Expected output word: integer products, low 16 bits, zero-flagged lanes forced to 0.
    function automatic logic [IO_W-1:0] model_word(input logic [IO_W-1:0] w, input bit sgn);
        logic [IO_W-1:0] r;
        int a, b, p;
        r = '0;
        r[IO_W-1 -: SIDE_W] = w[IO_W-1 -: SIDE_W];
        for (int i = 0; i < NL; i++) begin
            a = int'(w[i*16 +: 8]);
            b = int'(w[i*16+8 +: 8]);
            if (sgn && a > 127) a -= 256;
            if (sgn && b > 127) b -= 256;
            p = a * b;
            if (w[IO_W-SIDE_W+i]) p = 0;
            r[i*16 +: 16] = p[15:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (valid_out) begin
                if (q.size() == 0) begin
                    check("valid_out without pending word", valid_out, 0);
                end else begin
                    last_out = data_out;
                    check("data_out vs model", data_out, q.pop_front());
                    out_cnt++;
                    check("done vs job position", done, (out_cnt - job_start) == job_total);
                end
            end else begin
                check("done without valid_out", done, 0);
            end
            if (!avail_in) check("valid_out while stalled", valid_out, 0);
            if (s_valid_out) begin
                if (sq.size() == 0) begin
                    check("signed valid_out without pending word", s_valid_out, 0);
                end else begin
                    s_last_out  = s_data_out;
                    s_last_done = s_done;
                    check("signed data_out vs model", s_data_out, sq.pop_front());
                    s_out_cnt++;
                end
            end
        end
    end

    task automatic wr(input logic [IO_W-1:0] w, input bit to_sb);
        data_in  = w;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        if (to_sb) q.push_back(model_word(w, 1'b0));
    endtask

    task automatic cfg(input int it, input int rd);
        num_iters = 16'(it);
        num_reads = 16'(rd);
        job_start = out_cnt;
        job_total = it * rd;
        configure = 1'b1;
        @(negedge clk);
        configure = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget, input string name);
        int k;
        k = 0;
        while ((out_cnt - job_start) < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, out_cnt - job_start, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IO_W-1:0] w;
        int pat [4];
        int k;
        pat = '{1, 0, 0, 1};
        rst = 1'b0; configure = 1'b0; s_configure = 1'b0;
        num_iters = '0; num_reads = '0;
        data_in = '0; s_data_in = '0; valid_in = 1'b0; s_valid_in = 1'b0;
        avail_in = 1'b1;
        repeat (2) @(negedge clk);
        check("reset valid_out", valid_out, 0);
        check("reset done", done, 0);
        check("reset overflow", overflow, 0);
        check("reset avail_out", avail_out, 1);
        rst = 1'b1;
        @(negedge clk);

        // 1: unsigned products and exact latency
        wr(mk(3, 5, 255, 255, 0, 7, 16, 16, '0), 1'b1);
        cfg(1, 1);
        @(negedge clk);
        check("t1 no early valid", valid_out, 0);
        @(negedge clk);
        check("t1 valid at latency", valid_out, 1);
        check("t1 lane0", data_out[15:0], 15);
        check("t1 lane1", data_out[31:16], 65025);
        check("t1 lane2", data_out[47:32], 0);
        check("t1 lane3", data_out[63:48], 256);
        check("t1 done with valid", done, 1);

        // 2: signed instance
        w = mk(-128, -128, -1, 127, 0, 0, 0, 0, '0);
        s_data_in = w; s_valid_in = 1'b1;
        @(negedge clk);
        s_valid_in = 1'b0;
        sq.push_back(model_word(w, 1'b1));
        num_iters = 16'd1; num_reads = 16'd1; s_configure = 1'b1;
        @(negedge clk);
        s_configure = 1'b0;
        k = 0;
        while (s_out_cnt < 1 && k < 10) begin @(negedge clk); #1; k++; end
        check("t2 signed output count", s_out_cnt, 1);
        check("t2 (-128)*(-128)", s_last_out[15:0], 16'h4000);
        check("t2 (-1)*127", s_last_out[31:16], 16'hFF81);
        check("t2 signed done", s_last_done, 1);

        // 3: zero-flagged lane and side passthrough
        wr(mk(9, 9, 9, 9, 9, 9, 9, 9, 20'hA5A54), 1'b1);
        cfg(1, 1);
        wait_outs(1, 10, "t3 output count");
        check("t3 lane2 gated", last_out[47:32], 0);
        check("t3 lane0 ungated", last_out[15:0], 81);
        check("t3 side passthrough", last_out[IO_W-1 -: SIDE_W], 20'hA5A54);

        // 4: iters=2 reads=3 with 8 words streamed in
        cfg(2, 3);
        for (int i = 1; i <= 8; i++) wr(mk(i, i + 1, 2 * i, 3, 255 - i, 2, i, 17, '0), 1'b1);
        wait_outs(6, 40, "t4 six outputs");
        repeat (6) @(negedge clk);
        #1;
        check("t4 no seventh output", out_cnt - job_start, 6);
        cfg(1, 2);
        wait_outs(2, 20, "t4 two words left in fifo");

        // 5: stall pattern during a stream
        for (int i = 0; i < 4; i++) wr(mk(i + 20, 3, 7, i + 1, 100, 100, 1, 2, 20'(i)), 1'b1);
        cfg(1, 4);
        k = 0;
        while ((out_cnt - job_start) < 4 && k < 60) begin
            @(negedge clk);
            #1;
            avail_in = pat[k % 4] != 0;
            k++;
        end
        avail_in = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t5 exactly four outputs", out_cnt - job_start, 4);

        // zero configuration: nothing issues
        wr(mk(2, 2, 2, 2, 2, 2, 2, 2, '0), 1'b1);
        cfg(0, 5);
        repeat (8) @(negedge clk);
        #1;
        check("zero iters no issue", out_cnt - job_start, 0);
        cfg(1, 1);
        wait_outs(1, 10, "zero cfg word drains later");

        // 6: fill FIFO with no pops, then overflow, then async reset mid-stream
        for (int i = 1; i <= 6; i++) begin
            data_in  = mk(i, 3, i, 5, 1, 1, 2, 2, '0);
            valid_in = 1'b1;
            @(negedge clk);
            if (i <= 4) q.push_back(model_word(data_in, 1'b0));
            check($sformatf("t6 avail_out after write %0d", i), avail_out, i <= 2);
            check($sformatf("t6 overflow after write %0d", i), overflow, i >= 5);
        end
        valid_in = 1'b0;
        cfg(1, 4);
        wait_outs(1, 10, "t6 stream started");
        check("t6 valid_out before reset", valid_out, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6 reset clears valid_out", valid_out, 0);
        check("t6 reset clears overflow", overflow, 0);
        check("t6 reset frees fifo", avail_out, 1);
        check("t6 reset clears done", done, 0);
        q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t6 nothing after reset", out_cnt - job_start, 1);
        check("t6 overflow stays clear", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
